// File: rtl/uart_pixel_unpacker_if.sv
// Byte stream from the UART receiver in, RGB444 pixel strobes out.
// The unpacker uses the slave side.
interface uart_pixel_unpacker_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        rx_valid;
    logic [11:0] rx_data;

    modport master (output byte_valid, output byte_data, input rx_valid, input rx_data);
    modport slave  (input byte_valid, input byte_data, output rx_valid, output rx_data);
endinterface

// File: rtl/uart_pixel_unpacker.sv
// Unpacks a headered UART byte stream into W*H RGB444 pixels.
// Every three payload bytes become two pixels. A frame aborts on an inter-byte timeout.
module uart_pixel_unpacker #(
    parameter int unsigned W       = 200,
    parameter int unsigned H       = 150,
    parameter logic [7:0]  HDR0    = 8'hAA,
    parameter logic [7:0]  HDR1    = 8'h55,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            state,
    uart_pixel_unpacker_if.slave  bus,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [14:0]           pix_count
);

    localparam logic [7:0]  ST_XFER   = 8'h02;
    localparam logic [14:0] PIX_TOTAL = 15'(W * H);
    localparam int          TW        = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    typedef enum logic [2:0] {SYNC0, SYNC1, B0, B1, B2, DONE, ERR} fsm_t;

    fsm_t          fsm;
    logic [7:0]    hi;
    logic [3:0]    lo;
    logic [TW-1:0] tmo_cnt;
    logic [14:0]   pix_next;

    assign pix_next = pix_count + 15'd1;

    // NOTE: every register here is written with <= so all state moves together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm          <= SYNC0;
            hi           <= '0;
            lo           <= '0;
            tmo_cnt      <= '0;
            pix_count    <= '0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            bus.rx_valid <= 1'b0;
            bus.rx_data  <= '0;
        end else begin
            bus.rx_valid <= 1'b0;
            if (state != ST_XFER) begin
                // Leaving transfer wipes the frame, and this wins over any byte this cycle.
                fsm        <= SYNC0;
                hi         <= '0;
                lo         <= '0;
                tmo_cnt    <= '0;
                pix_count  <= '0;
                frame_done <= 1'b0;
                frame_err  <= 1'b0;
            end else begin
                unique case (fsm)
                    SYNC0: begin
                        if (bus.byte_valid && bus.byte_data == HDR0) fsm <= SYNC1;
                    end
                    SYNC1: begin
                        if (bus.byte_valid) begin
                            if (bus.byte_data == HDR1) begin
                                fsm     <= B0;
                                tmo_cnt <= '0;
                            end else if (bus.byte_data != HDR0) begin
                                fsm <= SYNC0;
                            end
                        end
                    end
                    B0, B1, B2: begin
                        if (bus.byte_valid) begin
                            tmo_cnt <= '0;
                            if (fsm == B0) begin
                                hi  <= bus.byte_data;
                                fsm <= B1;
                            end else if (fsm == B1) begin
                                bus.rx_valid <= 1'b1;
                                bus.rx_data  <= {hi, bus.byte_data[7:4]};
                                lo           <= bus.byte_data[3:0];
                                pix_count    <= pix_next;
                                fsm          <= B2;
                            end else begin
                                bus.rx_valid <= 1'b1;
                                bus.rx_data  <= {lo, bus.byte_data};
                                pix_count    <= pix_next;
                                if (pix_next == PIX_TOTAL) begin
                                    fsm        <= DONE;
                                    frame_done <= 1'b1;
                                end else begin
                                    fsm <= B0;
                                end
                            end
                        end else if (tmo_cnt == TMO_LIMIT) begin
                            fsm       <= ERR;
                            frame_err <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    default: ;  // DONE and ERR hold until state leaves transfer
                endcase
            end
        end
    end

endmodule

// File: doc/uart_pixel_unpacker.md
# uart_pixel_unpacker

Upstream stage of the image RAM writer. Converts the UART receiver's byte stream into 12-bit RGB444 pixels: it waits for a two-byte frame header, unpacks three bytes into two pixels, and emits one `rx_valid`/`rx_data` pulse per pixel. It counts exactly `W*H` pixels per frame, flags completion, and aborts on an inter-byte timeout. It only accepts a frame while the system `state` is `8'h02` (transfer).

## Interface
- `W`, default 200: image width in pixels.
- `H`, default 150: image height in pixels. `W*H` must be even.
- `HDR0`, default 8'hAA: first header byte.
- `HDR1`, default 8'h55: second header byte.
- `TIMEOUT`, default 50000: maximum clk cycles allowed between bytes inside a frame.

Ports:
- `clk` — in, 1: system clock. Everything is on the rising edge.
- `rst_n` — in, 1: reset, asynchronous, active-low.
- `state` — in, 8: system state. `8'h02` enables reception.
- `byte_valid` — in, 1: one-cycle strobe from the UART receiver.
- `byte_data` — in, 8: received byte, valid while `byte_valid` is high.
- `rx_valid` — out, 1: one-cycle pixel strobe to the RAM writer.
- `rx_data` — out, 12: pixel as {R[3:0], G[3:0], B[3:0]}.
- `frame_done` — out, 1: level. All `W*H` pixels have been delivered.
- `frame_err` — out, 1: level. The frame was aborted by a timeout.
- `pix_count` — out, 15: number of pixels emitted in the current frame.

## Operation
- FSM states: SYNC0, SYNC1, B0, B1, B2, DONE, ERR.
- When `state != 8'h02`, the FSM is forced to SYNC0 and the block clears `pix_count`, `frame_done`, `frame_err`, the timeout counter and the byte latch. This has priority over byte handling in the same cycle.
- SYNC0: a byte equal to `HDR0` moves to SYNC1. Any other byte is dropped.
- SYNC1:
  - a byte equal to `HDR1` moves to B0;
  - a byte equal to `HDR0` stays in SYNC1;
  - any other byte returns to SYNC0.
- B0: latch `hi = byte_data`, then go to B1.
- B1: emit P0 = {hi, byte_data[7:4]}, latch `lo = byte_data[3:0]`, then go to B2.
- B2: emit P1 = {lo, byte_data}.
  - If this was pixel `W*H`, go to DONE.
  - Otherwise go to B0.
- On every emit, `pix_count` increments by 1. The increment is computed at 15 bits and never wraps, because `W*H <= 32767`.
- DONE: `frame_done = 1`. All further bytes are ignored until `state` leaves `8'h02`.
- Timeout in B0, B1 and B2:
  - A 16-bit (minimum) counter resets on each `byte_valid` and otherwise increments.
  - When it reaches `TIMEOUT`, the FSM goes to ERR.
  - SYNC0 and SYNC1 do not time out.
- ERR: `frame_err = 1`. Bytes are ignored until `state` leaves `8'h02`. `pix_count` holds its value for diagnosis.
- Header bytes are never emitted as pixels.

## Timing
- Reset values: `rx_valid = 0`, `rx_data = 12'h000`, `frame_done = 0`, `frame_err = 0`, `pix_count = 0`. FSM = SYNC0, counters = 0.
- Latency: `rx_valid`/`rx_data` are registered. They assert on the clk edge after the edge that samples the completing byte (B1 or B2), for exactly one cycle.
- `rx_data` holds the last pixel value between strobes.
- Maximum output rate is one pixel per 2 cycles. The downstream consumer registers on posedge and writes on the following negedge, so no backpressure exists. `byte_valid` is guaranteed to be at most one per 2 cycles.
- `frame_done` rises in the same cycle as the final `rx_valid`.
- `frame_err` rises on the cycle after the counter reaches `TIMEOUT`.
- Byte arrival and timeout on the same cycle: the byte wins and the counter resets.
- Async reset mid-frame: all outputs return to reset values immediately. No partial pixel is emitted after reset is released.

## Test plan
- **Normal frame.** Use `W=4`, `H=2`, `state=02`. Send AA 55, then 12 bytes `12 34 56 ...`.
  - Required: 8 `rx_valid` pulses. The first two are 12'h123 and 12'h456.
  - `pix_count` ends at 8 and `frame_done = 1` coincides with the 8th pulse.
- **Header resync.** Send 00 AA AA 55 AB CD EF.
  - Required: the header is accepted at the second AA.
  - Pixels emitted: 12'hABC, then 12'hDEF.
- **Bad header.** Send AA 12 55 AB CD EF.
  - Required: no `rx_valid`, FSM stays in SYNC0, `pix_count = 0`.
- **Timeout.** Use `TIMEOUT=100`. Send AA 55 AB, then wait 100 idle cycles.
  - Required: `frame_err = 1`, `pix_count = 0`, and later bytes produce no `rx_valid`.
  - Drive `state=01`: `frame_err` clears.
- **Post-done bytes.** After `frame_done`, send 6 more bytes.
  - Required: no `rx_valid`, and `pix_count` stays at `W*H`.
- **Mid-frame state exit and reset.**
  - Case 1: after 3 pixels, set `state=01` then back to `02`. Required: `pix_count = 0`, and a fresh header is needed.
  - Case 2: assert `rst_n = 0` mid-byte. Required: all outputs are 0 immediately.
